// File: rtl/foc_sequencer.sv
// FOC stage sequencer: captures one motor-channel sample, starts each pipeline
// stage in turn, waits for its done (or fixed latency), flushes the stages, reports.
//
// state | meaning
// IDLE  | ready for a sample (unless a fault is pending)
// ISSUE | one-cycle start pulse to stage s, timeout counter cleared
// WAIT  | waiting for stage s to complete or time out
// FLUSH | one-cycle reset of the stage modules, result or fault reported
module foc_sequencer #(
   parameter int D_WIDTH = 16,
   parameter int N_CH = 2,
   parameter int N_STAGES = 6,
   parameter logic [N_STAGES-1:0] FIXED_MASK = 6'b001000,
   parameter int TIMEOUT = 255,
   localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1,
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CHW-1:0]      in_ch,
   input  logic [D_WIDTH-1:0]  angle_in,
   input  logic [D_WIDTH-1:0]  curr_a_in,
   input  logic [D_WIDTH-1:0]  curr_b_in,
   input  logic [D_WIDTH-1:0]  curr_c_in,
   input  logic [D_WIDTH-1:0]  curr_t_in,
   input  logic [D_WIDTH-1:0]  period_in,
   output logic [D_WIDTH-1:0]  cap_angle,
   output logic [D_WIDTH-1:0]  cap_a,
   output logic [D_WIDTH-1:0]  cap_b,
   output logic [D_WIDTH-1:0]  cap_c,
   output logic [D_WIDTH-1:0]  cap_t,
   output logic [D_WIDTH-1:0]  cap_period,
   output logic [CHW-1:0]      cur_ch,
   output logic [N_STAGES-1:0] stage_start,
   input  logic [N_STAGES-1:0] stage_done,
   output logic                mod_rstb,
   output logic                out_valid,
   output logic [CHW-1:0]      out_ch,
   output logic                fault,
   output logic [SW-1:0]       fault_stage,
   output logic [CHW-1:0]      fault_ch,
   input  logic                fault_clr,
   output logic                err_ch
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

   state_t        state, state_nx;
   logic [SW-1:0] s, s_nx;
   logic [TW-1:0] cnt, cnt_nx;
   logic          take, ch_ok, done_hit, at_limit, timeout, run_to;

   assign take     = in_valid && in_ready;
   assign ch_ok    = 32'(in_ch) < N_CH;
   assign done_hit = (state == WAIT) && (stage_done[s] || FIXED_MASK[s]);
   assign at_limit = (cnt == TW'(TIMEOUT));
   assign timeout  = (state == WAIT) && !done_hit && at_limit;

   always_comb begin
      state_nx  = state;
      s_nx      = s;
      cnt_nx    = cnt;
      in_ready  = 1'b0;
      mod_rstb  = 1'b1;
      out_valid = 1'b0;
      out_ch    = '0;
      case (state)
         IDLE: begin
            in_ready = !fault;
            if (take && ch_ok) begin
               s_nx     = '0;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            cnt_nx   = '0;
            state_nx = WAIT;
         end
         WAIT: begin
            if (done_hit) begin
               if (s == SW'(N_STAGES - 1)) begin
                  state_nx = FLUSH;
               end else begin
                  s_nx     = s + 1'b1;
                  state_nx = ISSUE;
               end
            end else if (at_limit) begin
               state_nx = FLUSH;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         FLUSH: begin
            mod_rstb  = 1'b0;
            out_valid = !run_to;
            out_ch    = run_to ? '0 : cur_ch;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state       <= IDLE;
         s           <= '0;
         cnt         <= '0;
         stage_start <= '0;
         err_ch      <= 1'b0;
         run_to      <= 1'b0;
         fault       <= 1'b0;
         fault_stage <= '0;
         fault_ch    <= '0;
         cur_ch      <= '0;
         cap_angle   <= '0;
         cap_a       <= '0;
         cap_b       <= '0;
         cap_c       <= '0;
         cap_t       <= '0;
         cap_period  <= '0;
      end else begin
         state       <= state_nx;
         s           <= s_nx;
         cnt         <= cnt_nx;
         stage_start <= (state_nx == ISSUE) ? (N_STAGES'(1) << s_nx) : '0;
         err_ch      <= take && !ch_ok;
         if (take && ch_ok) begin
            run_to     <= 1'b0;
            cur_ch     <= in_ch;
            cap_angle  <= angle_in;
            cap_a      <= curr_a_in;
            cap_b      <= curr_b_in;
            cap_c      <= curr_c_in;
            cap_t      <= curr_t_in;
            cap_period <= period_in;
         end else if (timeout) begin
            run_to <= 1'b1;
         end
         // a fresh timeout outranks a simultaneous clear
         if (timeout) begin
            fault       <= 1'b1;
            fault_stage <= s;
            fault_ch    <= cur_ch;
         end else if (fault_clr) begin
            fault       <= 1'b0;
            fault_stage <= '0;
            fault_ch    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_foc_sequencer.sv
// Directed bench for foc_sequencer: nominal run, early/stray done, illegal
// channel, done at the timeout limit, timeout fault, reset mid-run.
module tb_foc_sequencer;
   localparam int DW = 16;
   localparam int NCH = 3;   // three channels so that index 3 is illegal
   localparam int NS = 6;
   localparam int CHW = 2;
   localparam int SW = 3;

   logic clk = 1'b0;
   logic rstb = 1'b0;
   logic in_valid = 1'b0, in_ready;
   logic [CHW-1:0] in_ch = '0;
   logic [DW-1:0] angle_in = '0, curr_a_in = '0, curr_b_in = '0;
   logic [DW-1:0] curr_c_in = '0, curr_t_in = '0, period_in = '0;
   logic [DW-1:0] cap_angle, cap_a, cap_b, cap_c, cap_t, cap_period;
   logic [CHW-1:0] cur_ch, out_ch, fault_ch;
   logic [NS-1:0] stage_start, stage_done;
   logic mod_rstb, out_valid, fault, fault_clr = 1'b0, err_ch;
   logic [SW-1:0] fault_stage;

   logic [NS-1:0] auto_mask = 6'b110111;
   logic [NS-1:0] auto_done = '0, manual_done = '0, pend = '0;
   assign stage_done = auto_done | manual_done;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // stage model: done one cycle after its start pulse, for stages in auto_mask
   always @(negedge clk) begin
      auto_done = pend & auto_mask;
      pend = stage_start;
   end

   foc_sequencer #(.D_WIDTH(DW), .N_CH(NCH), .N_STAGES(NS),
                   .FIXED_MASK(6'b001000), .TIMEOUT(255)) dut (
      .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
      .in_ch(in_ch), .angle_in(angle_in), .curr_a_in(curr_a_in),
      .curr_b_in(curr_b_in), .curr_c_in(curr_c_in), .curr_t_in(curr_t_in),
      .period_in(period_in), .cap_angle(cap_angle), .cap_a(cap_a),
      .cap_b(cap_b), .cap_c(cap_c), .cap_t(cap_t), .cap_period(cap_period),
      .cur_ch(cur_ch), .stage_start(stage_start), .stage_done(stage_done),
      .mod_rstb(mod_rstb), .out_valid(out_valid), .out_ch(out_ch),
      .fault(fault), .fault_stage(fault_stage), .fault_ch(fault_ch),
      .fault_clr(fault_clr), .err_ch(err_ch)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [CHW-1:0] ch, input logic [DW-1:0] base);
      @(negedge clk);
      in_valid  = 1'b1;
      in_ch     = ch;
      angle_in  = base;
      curr_a_in = base + 16'd1;
      curr_b_in = base + 16'd2;
      curr_c_in = base + 16'd3;
      curr_t_in = base + 16'd4;
      period_in = base + 16'd5;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_nominal(input logic [CHW-1:0] ch, input logic [DW-1:0] base);
      logic [NS-1:0] e;
      auto_mask = 6'b110111;
      send(ch, base);
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         e = '0;
         if ((i % 2 == 1) && i <= 11) e[(i-1)/2] = 1'b1;
         chk($sformatf("nom_start c%0d", i), 32'(stage_start), 32'(e));
         chk($sformatf("nom_oval c%0d", i), 32'(out_valid), 32'(i == 13));
         chk($sformatf("nom_mrst c%0d", i), 32'(mod_rstb), 32'(i != 13));
         chk($sformatf("nom_rdy c%0d", i), 32'(in_ready), 32'(i == 14));
         if (i == 13) chk("nom_out_ch", 32'(out_ch), 32'(ch));
      end
      chk("nom_cap_angle", 32'(cap_angle), 32'(base));
      chk("nom_cap_c", 32'(cap_c), 32'(base + 16'd3));
      chk("nom_cap_period", 32'(cap_period), 32'(base + 16'd5));
      chk("nom_cur_ch", 32'(cur_ch), 32'(ch));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // reset values
      #1;
      chk("rst_rdy", 32'(in_ready), 32'd1);
      chk("rst_start", 32'(stage_start), 32'd0);
      chk("rst_mrst", 32'(mod_rstb), 32'd1);
      chk("rst_oval", 32'(out_valid), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_cap", 32'(cap_angle), 32'd0);
      @(negedge clk);
      @(negedge clk) rstb = 1'b1;

      // nominal run, channel 1
      run_nominal(2'd1, 16'h0100);

      // done held through ISSUE, stray bits, real done 4 cycles into WAIT
      auto_mask = 6'b111110;
      send(2'd0, 16'h0200);
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         manual_done = (i == 1 || i == 6) ? 6'b000001 :
                       (i >= 2 && i <= 5) ? 6'b000110 : 6'b000000;
         if (i == 3) chk("early_start", 32'(stage_start), 32'd0);
         if (i == 7) chk("early_s1", 32'(stage_start), 32'b000010);
         if (i == 16) chk("early_oval16", 32'(out_valid), 32'd0);
         if (i == 17) chk("early_oval17", 32'(out_valid), 32'd1);
      end

      // illegal channel
      send(2'd3, 16'h0777);
      @(negedge clk);
      chk("ill_err", 32'(err_ch), 32'd1);
      chk("ill_start", 32'(stage_start), 32'd0);
      @(negedge clk);
      chk("ill_err_end", 32'(err_ch), 32'd0);
      chk("ill_cap", 32'(cap_angle), 32'h0200);
      chk("ill_cur_ch", 32'(cur_ch), 32'd0);
      chk("ill_rdy", 32'(in_ready), 32'd1);

      // stage 0 done lands exactly when counter hits the limit
      auto_mask = 6'b111110;
      send(2'd1, 16'h0300);
      for (int i = 1; i <= 269; i++) begin
         @(negedge clk);
         manual_done = (i == 257) ? 6'b000001 : 6'b000000;
         if (i == 257 || i == 258 || i == 269) chk($sformatf("lim_fault c%0d", i), 32'(fault), 32'd0);
         if (i == 258) chk("lim_s1", 32'(stage_start), 32'b000010);
         if (i == 267) chk("lim_oval267", 32'(out_valid), 32'd0);
         if (i == 268) chk("lim_oval268", 32'(out_valid), 32'd1);
         if (i == 268) chk("lim_out_ch", 32'(out_ch), 32'd1);
      end

      // stage 2 never completes
      auto_mask = 6'b111011;
      send(2'd2, 16'h0400);
      for (int i = 1; i <= 265; i++) begin
         @(negedge clk);
         if (i == 5) chk("to_s2", 32'(stage_start), 32'b000100);
         if (i == 261) chk("to_fault_pre", 32'(fault), 32'd0);
         if (i == 262) begin
            chk("to_fault", 32'(fault), 32'd1);
            chk("to_stage", 32'(fault_stage), 32'd2);
            chk("to_ch", 32'(fault_ch), 32'd2);
            chk("to_mrst", 32'(mod_rstb), 32'd0);
            chk("to_oval", 32'(out_valid), 32'd0);
         end
         if (i == 265) chk("to_rdy", 32'(in_ready), 32'd0);
      end
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("clr_fault", 32'(fault), 32'd0);
      chk("clr_stage", 32'(fault_stage), 32'd0);
      chk("clr_rdy", 32'(in_ready), 32'd1);

      // reset during WAIT of stage 4
      auto_mask = 6'b110111;
      send(2'd1, 16'h0500);
      for (int i = 1; i <= 10; i++) @(negedge clk);
      rstb = 1'b0;
      #1;
      chk("mid_rdy", 32'(in_ready), 32'd1);
      chk("mid_start", 32'(stage_start), 32'd0);
      chk("mid_mrst", 32'(mod_rstb), 32'd1);
      chk("mid_cap", 32'(cap_period), 32'd0);
      chk("mid_cur_ch", 32'(cur_ch), 32'd0);
      @(negedge clk) rstb = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk($sformatf("mid_oval c%0d", i), 32'(out_valid), 32'd0);
         chk($sformatf("mid_mrst c%0d", i), 32'(mod_rstb), 32'd1);
      end
      run_nominal(2'd2, 16'h0600);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
